// File: rtl/instruction_decode.sv
// Second pipeline stage: assembles 1-3 byte instructions from the fetch byte stream
// and presents one decoded instruction at a time over a DOR/ack handshake.
module instruction_decode #(
  parameter logic [7:0] NOP_OPCODE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        DIR,
  input  logic [7:0]  data_in,
  output logic        ack_from_ID,
  output logic        DOR,
  input  logic        ack_to_ID,
  output logic [7:0]  opcode_out,
  output logic [15:0] operand_out,
  output logic [1:0]  length_out,
  output logic        illegal_out
);

  typedef enum logic [1:0] {StFetchOp, StFetchB1, StFetchB2, StOutValid} state_e;

  state_e      state_q, state_d;
  logic        armed_q, armed_d;
  logic        ack_q, ack_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] operand_q, operand_d;
  logic [1:0]  length_q, length_d;
  logic        illegal_q, illegal_d;
  logic [1:0]  extra_q, extra_d;
  logic        capture;

  // armed blocks a second capture while upstream still holds DIR after our ack
  assign capture = DIR && armed_q && (state_q != StOutValid) && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetchOp;
      armed_q   <= 1'b1;
      ack_q     <= 1'b0;
      opcode_q  <= NOP_OPCODE;
      operand_q <= '0;
      length_q  <= '0;
      illegal_q <= 1'b0;
      extra_q   <= '0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      ack_q     <= ack_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      length_q  <= length_d;
      illegal_q <= illegal_d;
      extra_q   <= extra_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    ack_d     = 1'b0;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    length_d  = length_q;
    illegal_d = illegal_q;
    extra_d   = extra_q;
    if (flush) begin
      state_d   = StFetchOp;
      opcode_d  = NOP_OPCODE;
      operand_d = '0;
      length_d  = '0;
      illegal_d = 1'b0;
    end else begin
      if (!DIR) armed_d = 1'b1;
      if (capture) begin
        armed_d = 1'b0;
        ack_d   = 1'b1;
        unique case (state_q)
          StFetchOp: begin
            opcode_d  = data_in;
            operand_d = '0;
            illegal_d = 1'b0;
            extra_d   = data_in[7:6];
            unique case (data_in[7:6])
              2'd0: begin
                length_d = 2'd1;
                state_d  = StOutValid;
              end
              2'd3: begin
                length_d  = 2'd0;
                illegal_d = 1'b1;
                state_d   = StOutValid;
              end
              default: begin
                length_d = 2'd0;
                state_d  = StFetchB1;
              end
            endcase
          end
          StFetchB1: begin
            operand_d[7:0] = data_in;
            if (extra_q == 2'd1) begin
              length_d = 2'd2;
              state_d  = StOutValid;
            end else begin
              state_d = StFetchB2;
            end
          end
          StFetchB2: begin
            operand_d[15:8] = data_in;
            length_d        = 2'd3;
            state_d         = StOutValid;
          end
          StOutValid: ;
        endcase
      end else if (state_q == StOutValid && ack_to_ID) begin
        state_d = StFetchOp;
      end
    end
  end

  always_comb begin
    DOR         = (state_q == StOutValid);
    ack_from_ID = ack_q;
    opcode_out  = opcode_q;
    operand_out = operand_q;
    length_out  = length_q;
    illegal_out = illegal_q;
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: hand-computed expectations for each scenario.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        DIR;
  logic [7:0]  data_in;
  logic        ack_from_ID;
  logic        DOR;
  logic        ack_to_ID;
  logic [7:0]  opcode_out;
  logic [15:0] operand_out;
  logic [1:0]  length_out;
  logic        illegal_out;

  int checks   = 0;
  int failures = 0;

  instruction_decode #(.NOP_OPCODE(8'h00)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .DIR         (DIR),
    .data_in     (data_in),
    .ack_from_ID (ack_from_ID),
    .DOR         (DOR),
    .ack_to_ID   (ack_to_ID),
    .opcode_out  (opcode_out),
    .operand_out (operand_out),
    .length_out  (length_out),
    .illegal_out (illegal_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Capture edge with ack check, then one DIR-low edge to re-arm.
  task automatic send_byte(input logic [7:0] b);
    DIR     = 1'b1;
    data_in = b;
    step();
    check("send_ack", ack_from_ID, 1);
    DIR = 1'b0;
    step();
    check("send_ack_end", ack_from_ID, 0);
  endtask

  task automatic accept();
    ack_to_ID = 1'b1;
    step();
    ack_to_ID = 1'b0;
    check("accept_dor", DOR, 0);
  endtask

  task automatic check_out(input string tag, input logic [7:0] op, input logic [15:0] opd,
                           input logic [1:0] len, input logic ill);
    check({tag, "_dor"}, DOR, 1);
    check({tag, "_op"}, opcode_out, op);
    check({tag, "_opd"}, operand_out, opd);
    check({tag, "_len"}, length_out, len);
    check({tag, "_ill"}, illegal_out, ill);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dor"}, DOR, 0);
    check({tag, "_ack"}, ack_from_ID, 0);
    check({tag, "_op"}, opcode_out, 8'h00);
    check({tag, "_opd"}, operand_out, 0);
    check({tag, "_len"}, length_out, 0);
    check({tag, "_ill"}, illegal_out, 0);
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    DIR       = 1'b0;
    data_in   = 8'h00;
    ack_to_ID = 1'b0;
    #12;
    check_reset_vals("reset");
    reset = 1'b1;
    step();

    // 1-byte instruction; DOR coincides with the ack pulse
    DIR     = 1'b1;
    data_in = 8'h12;
    step();
    check("one_ack", ack_from_ID, 1);
    check_out("one", 8'h12, 16'h0000, 2'd1, 1'b0);
    DIR = 1'b0;
    step();
    check("one_ack_end", ack_from_ID, 0);
    check("one_dor_hold", DOR, 1);
    accept();

    // 3-byte instruction, little-endian operand
    send_byte(8'h85);
    check("three_b0_dor", DOR, 0);
    send_byte(8'h34);
    check("three_b1_dor", DOR, 0);
    send_byte(8'h12);
    check_out("three", 8'h85, 16'h1234, 2'd3, 1'b0);
    accept();

    // Illegal opcode clears stale operand; next legal opcode clears illegal
    send_byte(8'hC7);
    check_out("illegal", 8'hC7, 16'h0000, 2'd0, 1'b1);
    accept();
    send_byte(8'h03);
    check_out("legal", 8'h03, 16'h0000, 2'd1, 1'b0);
    accept();

    // Held DIR: one capture only until DIR drops
    DIR     = 1'b1;
    data_in = 8'h01;
    step();
    check("held_ack1", ack_from_ID, 1);
    check_out("held", 8'h01, 16'h0000, 2'd1, 1'b0);
    ack_to_ID = 1'b1;
    step();
    ack_to_ID = 1'b0;
    check("held_ack2", ack_from_ID, 0);
    check("held_dor2", DOR, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("held_noack", ack_from_ID, 0);
      check("held_nodor", DOR, 0);
    end
    DIR     = 1'b0;
    data_in = 8'h02;
    step();
    DIR = 1'b1;
    step();
    check("held_rearm_ack", ack_from_ID, 1);
    check_out("held2", 8'h02, 16'h0000, 2'd1, 1'b0);
    DIR = 1'b0;
    accept();

    // Backpressure: no capture while DOR held
    send_byte(8'h05);
    DIR     = 1'b1;
    data_in = 8'h99;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_noack", ack_from_ID, 0);
      check("bp_op", opcode_out, 8'h05);
      check("bp_dor", DOR, 1);
    end
    accept();
    check("bp_accept_noack", ack_from_ID, 0);
    step();
    // Still armed, so the held 0x99 is captured on the next edge
    check("bp_next_ack", ack_from_ID, 1);
    check("bp_next_op", opcode_out, 8'h99);
    check("bp_next_dor", DOR, 0);
    DIR = 1'b0;
    step();

    // Flush from FETCH_B1 with a byte presented
    flush   = 1'b1;
    DIR     = 1'b1;
    data_in = 8'hAA;
    step();
    flush = 1'b0;
    DIR   = 1'b0;
    check_reset_vals("flush1");
    step();
    send_byte(8'h41);
    flush   = 1'b1;
    DIR     = 1'b1;
    data_in = 8'hAA;
    step();
    flush = 1'b0;
    DIR   = 1'b0;
    check_reset_vals("flush2");
    step();
    // Back in FETCH_OP: a 1-byte opcode completes immediately
    send_byte(8'h05);
    check_out("post_flush", 8'h05, 16'h0000, 2'd1, 1'b0);
    accept();

    // Asynchronous reset in FETCH_B2, right after a capture edge
    send_byte(8'h85);
    DIR     = 1'b1;
    data_in = 8'h34;
    step();
    check("rst_pre_ack", ack_from_ID, 1);
    DIR = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check_reset_vals("async_rst");
    #2;
    reset = 1'b1;
    step();
    send_byte(8'h12);
    check_out("post_rst", 8'h12, 16'h0000, 2'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Second pipeline stage. Sits directly downstream of instruction_fetch.
- Consumes the 8-bit instruction byte stream over the DIR/ack handshake.
- Assembles variable-length instructions of 1–3 bytes and presents one decoded instruction to the next stage over a DOR/ack handshake.
- Handles one instruction at a time; no overlap between output hold and next fetch.

Parameters:
- NOP_OPCODE, 8'h00, value driven on opcode_out after reset and after flush.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; low clears all state immediately
- flush  input  1  synchronous; discards any partial or held instruction
- DIR  input  1  upstream byte valid (fetch stage DOR)
- data_in  input  8  upstream byte; stable while DIR high
- ack_from_ID  output  1  one-cycle pulse: byte on data_in consumed
- DOR  output  1  decoded instruction valid
- ack_to_ID  input  1  downstream accepts decoded instruction
- opcode_out  output  8  first byte of instruction
- operand_out  output  16  operand bytes, little-endian (byte1 -> [7:0], byte2 -> [15:8]); unused bytes 0
- length_out  output  2  total instruction length in bytes (1..3); 0 for illegal
- illegal_out  output  1  opcode length field reserved

Behaviour:
- Reset values (reset low): state=FETCH_OP, DOR=0, ack_from_ID=0, opcode_out=NOP_OPCODE, operand_out=0, length_out=0, illegal_out=0, armed=1.
- Length encoding: opcode[7:6] gives the number of extra bytes, 0..2. Value 3 is illegal.
- armed flag:
  - Cleared on every byte capture.
  - Set on any edge where DIR is sampled 0.
  - A byte is captured only when DIR=1 and armed=1 and state is FETCH_OP/FETCH_B1/FETCH_B2.
  - This prevents double capture while upstream drops DIR after ack.
- Capture at edge N drives ack_from_ID=1 during cycle N+1 only. It is registered, never combinational from DIR.
- States:
  - FETCH_OP, on capture:
    - Latch opcode_out=data_in and clear operand_out.
    - extra=0 -> OUT_VALID, length_out=1.
    - extra=1/2 -> FETCH_B1.
    - extra=3 -> OUT_VALID, illegal_out=1, length_out=0, operand_out=0.
  - FETCH_B1, on capture:
    - operand_out[7:0]=data_in.
    - If extra=1 -> OUT_VALID, length_out=2; else -> FETCH_B2.
  - FETCH_B2, on capture: operand_out[15:8]=data_in, length_out=3 -> OUT_VALID.
  - OUT_VALID:
    - DOR=1; outputs held stable; no byte capture regardless of DIR.
    - On edge with ack_to_ID=1 -> FETCH_OP and DOR=0 next cycle.
    - Outputs keep their last values until the next opcode capture.
    - illegal_out clears at the next opcode capture.
- Latency:
  - DOR rises the cycle after the capture edge of the final byte, coincident with that byte's ack pulse.
  - The earliest next opcode capture is the edge after the ack_to_ID edge, provided armed=1.
- flush:
  - Wins over every other event in the same cycle.
  - Next state FETCH_OP, DOR=0, length_out=0, illegal_out=0, operand_out=0, opcode_out=NOP_OPCODE.
  - No capture and no ack pulse is generated on the flush edge.
  - armed is left unchanged.
- ack_to_ID while DOR=0 is ignored.
- DIR=1 with armed=0 is ignored until DIR returns low for at least one edge.
- Reset asserted mid-instruction drops DOR and the ack pulse asynchronously. The partial instruction is lost.

Test Plan:
- 1-byte: after reset, DIR=1 with data_in=8'h12 for one edge, then DIR=0 -> ack_from_ID pulse for 1 cycle; DOR=1 with opcode_out=12, operand_out=0000, length_out=1; ack_to_ID one cycle -> DOR=0 next cycle.
- 3-byte: bytes 8'h85, 8'h34, 8'h12, each with DIR dropped between them -> three ack pulses; DOR=1 with opcode_out=85, operand_out=1234, length_out=3, illegal_out=0.
- Held DIR: DIR=1 constant for 4 edges with data_in=8'h01 -> exactly one ack pulse and one capture; second instruction captured only after DIR low for one edge.
- Illegal: byte 8'hC7 -> DOR=1 with illegal_out=1, length_out=0, operand_out=0; after ack_to_ID, next byte 8'h03 gives illegal_out=0.
- Backpressure: DOR=1 with ack_to_ID=0 for 10 cycles while DIR=1 with new data -> no ack pulses and outputs unchanged; then ack_to_ID=1 for one edge -> DOR drops.
- Flush/reset: byte 8'h41 captured, flush asserted together with DIR=1 byte 8'hAA -> no ack pulse, state FETCH_OP, opcode_out=00. Separately, reset pulled low in FETCH_B2 -> all outputs at reset values without a clock edge.
